seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter BLINK_FRAMES, default 64, meaning the number of scan frames per blink half-period (minimum 1).
REQ-002 SHALL have port Clk2  in  1  scan clock; all state advances on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wr_en  in  1  write strobe into the shadow digit buffer.
REQ-005 SHALL have port wr_addr  in  2  shadow digit index (0 = least significant, 3 = most significant).
REQ-006 SHALL have port wr_data  in  4  hex digit value to write.
REQ-007 SHALL have port commit  in  1  request to copy shadow to active at the next frame boundary.
REQ-008 SHALL have port lz_blank  in  1  leading-zero blanking enable.
REQ-009 SHALL have port blink_mask  in  4  per-digit blink select.
REQ-010 SHALL have port an  out  4  digit enables, active-low, one-hot-low.
REQ-011 SHALL have port seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port commit_pending  out  1  high while a commit is waiting for a frame boundary.
REQ-013 SHALL have port frame_start  out  1  one-cycle pulse on the cycle in which digit 0 is driven.

Function
REQ-014 SHALL drive an, seg and frame_start from registers; scan index idx (2 bits) SHALL advance 0,1,2,3,0,... once per Clk2 edge, with wrap from 3 to 0.
REQ-015 SHALL drive digit 0 on the first edge after reset release: an=4'b1110, frame_start=1.
REQ-016 SHALL drive an=~(1<<idx) and seg=decode(active[idx]) for each driven digit, except that blanked digits SHALL have an bit high and seg=7'h7F.
REQ-017 SHALL decode the full hex range 0-F; reference codes: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110.
REQ-018 SHALL update shadow[wr_addr] with wr_data on the edge where wr_en=1; active digits SHALL be unaffected by the write.
REQ-019 SHALL set commit_pending on the edge where commit=1; a commit received while already pending SHALL have no additional effect.
REQ-020 SHALL copy all four shadow digits to active on the edge that drives digit 0 when commit_pending=1, and SHALL clear commit_pending on that same edge; that digit 0 SHALL show the new value.
REQ-021 SHALL write through a simultaneous wr_en into the copied value on the same edge as the copy, so the new digit is included.
REQ-022 SHALL treat commit=1 arriving on the boundary edge itself as an immediate copy: pending is set and cleared together, so commit_pending remains 0.
REQ-023 SHALL, when lz_blank=1, blank digit i (i=3,2,1) if active digits i..3 are all zero; digit 0 SHALL never be blanked by this rule.

Reset
REQ-024 SHALL, while reset=0, force an=4'b1111, seg=7'h7F, frame_start=0, commit_pending=0, idx=0, and clear all shadow and active digits to 0, regardless of the clock.
REQ-025 SHALL discard any pending commit and in-flight write on reset asserted mid-frame; after release, scanning SHALL restart per REQ-015.

Configuration
REQ-026 SHALL, with macro SEG_BLINK_EN defined, include a frame counter (0..BLINK_FRAMES-1, advanced on each frame_start) and a blink phase bit that toggles on counter wrap; in the off phase, digits with blink_mask bit set SHALL be blanked; counter and phase SHALL reset to 0 with the phase in the on state.
REQ-027 SHALL, without SEG_BLINK_EN, omit the counter and phase entirely and ignore blink_mask.

Structure
REQ-028 SHALL place NUM_DIGITS=4, SEG_BLANK=7'h7F and the hex-to-segment code table constants in shared package seg_scan_pkg.
REQ-029 SHALL instantiate one combinational sub-module seg_hex_decode (4-bit in, 7-bit active-low out); all other logic stays in seg_scan_driver.

Verification
REQ-030 SHALL verify reset release: reset 0 to 1, 8 edges -> an sequence 1110,1101,1011,0111 repeating, seg=7'b1000000 on every digit, frame_start high every 4th edge.
REQ-031 SHALL verify tear-free commit: write shadow 3..0 = 1,2,3,4 and pulse commit mid-frame (idx=2) -> digits 2 and 3 keep old values, commit_pending=1 until the next digit-0 edge, then digits show 4,3,2,1 with commit_pending=0.
REQ-032 SHALL verify the boundary race: wr_en addr 0 data 9 together with commit on the digit-0 edge -> digit 0 shows 9 on that edge and commit_pending stays 0.
REQ-033 SHALL verify leading-zero blanking: active 3..0 = 0,0,5,0 with lz_blank=1 -> an bits 3 and 2 stay high, digit 1 shows 5, digit 0 shows 0; with active all zero, only digit 0 is lit.
REQ-034 SHALL verify blink with SEG_BLINK_EN and BLINK_FRAMES=2, blink_mask=4'b0001 -> digit 0 is lit for 2 frames and blank for 2 frames alternately, while other digits are always lit.
REQ-035 SHALL verify mid-operation reset: reset pulsed low with commit_pending=1 -> outputs show blank immediately, and after release all digits show 0 with commit_pending=0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_scan_pkg                                                 |
// | Description : Shared constants, types and helpers for the four-digit       |
// |               multiplexed seven-segment scan driver.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seg_scan_pkg;

  // Number of multiplexed digit positions.
  localparam int NUM_DIGITS = 4;

  // Segment pattern with every segment off (active-low outputs).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One hex digit value and one scan position.
  typedef logic [3:0] hex_t;
  typedef logic [1:0] digit_idx_t;

  // Active-low segment codes {g,f,e,d,c,b,a}, indexed by the hex value.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // Active-low one-hot digit enable for a scan position.
  function automatic logic [3:0] digit_enable(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_hex_decode                                               |
// | Description : Combinational hex (0-F) to active-low seven-segment decode.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Table lookup; every 4-bit value has an entry so no default is needed.
  always_comb begin
    seg_o = SEG_CODES[hex_i];
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_scan_driver                                              |
// | Description : Four-digit multiplexed seven-segment scan driver with a      |
// |               double-buffered digit store (shadow -> active copy only at   |
// |               a frame boundary), leading-zero blanking and optional blink. |
// |               Optional feature macro: SEG_BLINK_EN (per-digit blink with   |
// |               BLINK_FRAMES frames per half-period). Default build omits it.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       Clk2,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  input  logic       lz_blank,
  input  logic [3:0] blink_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       commit_pending,
  output logic       frame_start
);

  // Scan position of the digit driven on the next edge.
  digit_idx_t idx_q, idx_d;

  // Shadow (written by the host) and active (displayed) digit stores.
  hex_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
  hex_t [NUM_DIGITS-1:0] active_q, active_d;

  // Registered outputs.
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       commit_pending_q, commit_pending_d;
  logic       frame_start_q, frame_start_d;

  // Per-edge combinational helpers.
  logic       w_boundary;
  logic       w_commit_req;
  logic [3:0] w_lz_blank;
  logic [3:0] w_blink_blank;
  logic       w_digit_blank;
  hex_t       w_cur_digit;
  logic [6:0] w_cur_seg;

  assign an             = an_q;
  assign seg            = seg_q;
  assign commit_pending = commit_pending_q;
  assign frame_start    = frame_start_q;

  // Buffer update: host write into shadow, and the tear-free copy to active
  // on the edge that drives digit 0. The copy takes the shadow value that
  // already includes a same-edge write, and a commit arriving on that very
  // edge is honoured immediately so the pending flag never rises.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d[wr_addr] = wr_data;
    end

    w_boundary       = (idx_q == 2'd0);
    w_commit_req     = commit_pending_q | commit;
    active_d         = active_q;
    commit_pending_d = w_commit_req;

    if (w_boundary && w_commit_req) begin
      active_d         = shadow_d;
      commit_pending_d = 1'b0;
    end
  end

  // Leading-zero blanking: a digit goes dark when it and every more
  // significant digit are zero. Digit 0 always stays lit so a zero value
  // still shows a single "0". Evaluated on the post-copy digits so the new
  // frame is blanked consistently from its first digit.
  always_comb begin
    w_lz_blank = 4'h0;
    if (lz_blank) begin
      w_lz_blank[3] = (active_d[3] == 4'h0);
      w_lz_blank[2] = w_lz_blank[3] && (active_d[2] == 4'h0);
      w_lz_blank[1] = w_lz_blank[2] && (active_d[1] == 4'h0);
    end
  end

`ifdef SEG_BLINK_EN
  // Frame counter width; a one-frame half-period still needs one bit.
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               blink_off_q, blink_off_d;

  // Count frames and flip the blink phase every BLINK_FRAMES frames. The
  // count advances as the last digit of a frame is driven, so each phase
  // change lands exactly on the next frame_start and a whole frame always
  // sees one phase.
  always_comb begin
    frame_d     = frame_q;
    blink_off_d = blink_off_q;
    if (idx_q == 2'd3) begin
      if (frame_q == FRAME_LAST) begin
        frame_d     = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Blink phase state; starts in the lit phase after reset.
  always_ff @(posedge Clk2 or negedge reset) begin
    if (!reset) begin
      frame_q     <= '0;
      blink_off_q <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign w_blink_blank = blink_off_q ? blink_mask : 4'h0;
`else
  // Blink disabled: the mask input and the frame parameter have no effect.
  assign w_blink_blank = 4'h0;

  logic unused_blink;
  assign unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
`endif

  // Digit about to be driven, taken from the post-copy store so digit 0 of
  // a committed frame already shows the new value.
  assign w_cur_digit = active_d[idx_q];

  seg_hex_decode u_hex_decode (
    .hex_i (w_cur_digit),
    .seg_o (w_cur_seg)
  );

  // Next output pattern and scan position.
  always_comb begin
    w_digit_blank = w_lz_blank[idx_q] | w_blink_blank[idx_q];
    an_d          = w_digit_blank ? 4'hF : digit_enable(idx_q);
    seg_d         = w_digit_blank ? SEG_BLANK : w_cur_seg;
    frame_start_d = w_boundary;
    idx_d         = idx_q + 2'd1;
  end

  // Main state and output registers; reset blanks the display and drops
  // any pending commit or buffered digit.
  always_ff @(posedge Clk2 or negedge reset) begin
    if (!reset) begin
      idx_q            <= 2'd0;
      shadow_q         <= '0;
      active_q         <= '0;
      an_q             <= 4'hF;
      seg_q            <= SEG_BLANK;
      commit_pending_q <= 1'b0;
      frame_start_q    <= 1'b0;
    end else begin
      idx_q            <= idx_d;
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      an_q             <= an_d;
      seg_q            <= seg_d;
      commit_pending_q <= commit_pending_d;
      frame_start_q    <= frame_start_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg_scan_driver                                           |
// | Description : Self-checking bench for seg_scan_driver: frame-level model   |
// |               compared every cycle, plus directed literal checks.          |
// |               Honours SEG_BLINK_EN (blink scenario with BLINK_FRAMES=2).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg_scan_driver;

`ifdef SEG_BLINK_EN
  localparam int TB_BF = 2;
`else
  localparam int TB_BF = 64;
`endif

  logic       Clk2 = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       commit;
  logic       lz_blank;
  logic [3:0] blink_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       commit_pending;
  logic       frame_start;

  int n_checks = 0;
  int n_errors = 0;

  seg_scan_driver #(.BLINK_FRAMES(TB_BF)) dut (
    .Clk2           (Clk2),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit         (commit),
    .lz_blank       (lz_blank),
    .blink_mask     (blink_mask),
    .an             (an),
    .seg            (seg),
    .commit_pending (commit_pending),
    .frame_start    (frame_start)
  );

  always #5 Clk2 = ~Clk2;

  // Independent hex to active-low {g,f,e,d,c,b,a} table.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_shadow [4] = '{default: 4'h0};
  logic [3:0] m_active [4] = '{default: 4'h0};
  bit         m_pend  = 1'b0;
  int         m_edges = 0;            // edges since reset release
  logic [3:0] m_an    = 4'hF;
  logic [6:0] m_seg   = 7'h7F;
  bit         m_fs    = 1'b0;

  always @(posedge Clk2 or negedge reset) begin : model
    int m_d;
    bit m_blank;
    bit m_nz;
    if (!reset) begin
      m_shadow = '{default: 4'h0};
      m_active = '{default: 4'h0};
      m_pend   = 1'b0;
      m_edges  = 0;
      m_an     = 4'hF;
      m_seg    = 7'h7F;
      m_fs     = 1'b0;
    end else begin
      m_d = m_edges % 4;
      if (wr_en) m_shadow[wr_addr] = wr_data;
      if (commit) m_pend = 1'b1;
      if (m_d == 0 && m_pend) begin
        m_active = m_shadow;
        m_pend   = 1'b0;
      end
      m_blank = 1'b0;
      if (lz_blank && m_d > 0) begin
        m_nz = 1'b0;
        for (int j = 0; j < 4; j++) if (j >= m_d && m_active[j] != 4'h0) m_nz = 1'b1;
        m_blank = !m_nz;
      end
`ifdef SEG_BLINK_EN
      if (blink_mask[m_d] && (((m_edges / 4) / TB_BF) % 2 == 1)) m_blank = 1'b1;
`endif
      m_an    = m_blank ? 4'hF : ~(4'b0001 << m_d);
      m_seg   = m_blank ? 7'h7F : hex7(m_active[m_d]);
      m_fs    = (m_d == 0);
      m_edges = m_edges + 1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge Clk2) begin
    chk("cmp_an", an, m_an);
    chk("cmp_seg", seg, m_seg);
    chk("cmp_frame_start", frame_start, m_fs);
    chk("cmp_commit_pending", commit_pending, m_pend);
  end

  // ---------------- stimulus ----------------
  logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  bit         lit_pat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  task automatic cyc(input logic we, input logic [1:0] a, input logic [3:0] d, input logic c);
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    commit  = c;
    @(negedge Clk2);
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic align0();
    for (int k = 0; k < 4; k++) if (m_edges % 4 != 0) cyc(1'b0, 2'd0, 4'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0;
    commit = 1'b0; lz_blank = 1'b0; blink_mask = 4'h0;
    @(negedge Clk2);
    @(negedge Clk2);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_fs", frame_start, 1'b0);
    chk("reset_cp", commit_pending, 1'b0);
    reset = 1'b1;

    // Reset release: scan order, all zeros, frame_start every 4th edge.
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 2'd0, 4'h0, 1'b0);
      chk("rel_an", an, an_seq[k % 4]);
      chk("rel_seg", seg, 7'b1000000);
      chk("rel_fs", frame_start, (k % 4 == 0));
    end

    // Tear-free commit: load shadow 3..0 = 1,2,3,4 then commit at digit 2.
    cyc(1'b1, 2'd3, 4'h1, 1'b0);
    chk("wr_no_effect_seg", seg, 7'b1000000);
    cyc(1'b1, 2'd2, 4'h2, 1'b0);
    cyc(1'b1, 2'd1, 4'h3, 1'b0);
    cyc(1'b1, 2'd0, 4'h4, 1'b0);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    cyc(1'b0, 2'd0, 4'h0, 1'b1);
    chk("tf_d2_cp", commit_pending, 1'b1);
    chk("tf_d2_an", an, 4'b1011);
    chk("tf_d2_seg_old", seg, 7'b1000000);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("tf_d3_cp", commit_pending, 1'b1);
    chk("tf_d3_seg_old", seg, 7'b1000000);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("tf_d0_cp", commit_pending, 1'b0);
    chk("tf_d0_seg", seg, 7'b0011001);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("tf_d1_seg", seg, 7'b0110000);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("tf_d2_seg", seg, 7'b0100100);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("tf_d3_seg", seg, 7'b1111001);

    // Boundary race: write digit 0 = 9 with commit on the digit-0 edge.
    align0();
    cyc(1'b1, 2'd0, 4'h9, 1'b1);
    chk("race_an", an, 4'hE);
    chk("race_seg", seg, 7'b0010000);
    chk("race_cp", commit_pending, 1'b0);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("race_cp_next", commit_pending, 1'b0);
    chk("race_d1_seg", seg, 7'b0110000);

    // Leading-zero blanking with active 3..0 = 0,0,5,0.
    lz_blank = 1'b1;
    align0();
    cyc(1'b1, 2'd3, 4'h0, 1'b0);
    cyc(1'b1, 2'd2, 4'h0, 1'b0);
    cyc(1'b1, 2'd1, 4'h5, 1'b0);
    cyc(1'b1, 2'd0, 4'h0, 1'b1);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("lz_d0_an", an, 4'hE);
    chk("lz_d0_seg", seg, 7'b1000000);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("lz_d1_an", an, 4'hD);
    chk("lz_d1_seg", seg, 7'b0010010);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("lz_d2_an", an, 4'hF);
    chk("lz_d2_seg", seg, 7'h7F);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("lz_d3_an", an, 4'hF);
    // All zero: only digit 0 lit.
    cyc(1'b1, 2'd1, 4'h0, 1'b1);
    chk("lz0_d0_an", an, 4'hE);
    chk("lz0_d0_seg", seg, 7'b1000000);
    for (int k = 1; k < 4; k++) begin
      cyc(1'b0, 2'd0, 4'h0, 1'b0);
      chk("lz0_an", an, 4'hF);
      chk("lz0_seg", seg, 7'h7F);
    end

    // Mid-operation reset with a commit pending.
    lz_blank = 1'b0;
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    cyc(1'b1, 2'd2, 4'h7, 1'b1);
    chk("mr_cp_before", commit_pending, 1'b1);
    chk("mr_an_before", an, 4'hD);
    #2 reset = 1'b0;
    #1;
    chk("mr_an_async", an, 4'hF);
    chk("mr_seg_async", seg, 7'h7F);
    chk("mr_cp_async", commit_pending, 1'b0);
    chk("mr_fs_async", frame_start, 1'b0);
    @(negedge Clk2);
    @(negedge Clk2);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 2'd0, 4'h0, 1'b0);
      chk("mr_an", an, an_seq[k]);
      chk("mr_seg", seg, 7'b1000000);
      chk("mr_cp", commit_pending, 1'b0);
    end
    cyc(1'b0, 2'd0, 4'h0, 1'b1);
    chk("mr_commit_d0_seg", seg, 7'b1000000);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    chk("mr_shadow_cleared_d2", seg, 7'b1000000);

`ifdef SEG_BLINK_EN
    // Blink digit 0: two frames lit, two frames dark, repeating.
    reset = 1'b0;
    @(negedge Clk2);
    blink_mask = 4'b0001;
    reset = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int d = 0; d < 4; d++) begin
        cyc(1'b0, 2'd0, 4'h0, 1'b0);
        if (d == 0) begin
          chk("blink_d0_an", an, lit_pat[f % 4] ? 4'hE : 4'hF);
          chk("blink_d0_seg", seg, lit_pat[f % 4] ? 7'b1000000 : 7'h7F);
        end else begin
          chk("blink_other_an", an, an_seq[d]);
        end
      end
    end
`else
    // Blink absent: the mask must not darken any digit.
    blink_mask = 4'hF;
    align0();
    for (int f = 0; f < 3; f++) begin
      for (int d = 0; d < 4; d++) begin
        cyc(1'b0, 2'd0, 4'h0, 1'b0);
        chk("noblink_an", an, an_seq[d]);
        chk("noblink_seg", seg, 7'b1000000);
      end
    end
    if (lit_pat[2]) chk("noblink_pat", an, 4'hE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
